// File: rtl/forward_hazard_ctrl.sv
// forward_hazard_ctrl: operand-forwarding selects and load-use stall control
// for a classic 5-stage pipeline. Keeps its own shadow ID/EX, EX/MEM and
// MEM/WB control fields so every decision is self-contained.
//
// Build option: define HAZ_FORWARD_EN to enable forwarding with a one-cycle
// load-use stall. Without it, the selects are tied to 0 and any RAW hazard
// against ID/EX or EX/MEM stalls until the producer reaches MEM/WB.
module forward_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_uses_rt_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic              stall_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              idex_bubble_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_WB  = 2'd2;

  // ID/EX shadow (_p0)
  logic [REG_AW-1:0] rs_p0, rt_p0, rd_p0;
  logic              regwrite_p0, memread_p0;
  // EX/MEM shadow (_p1)
  logic [REG_AW-1:0] rd_p1;
  logic              regwrite_p1;
  // MEM/WB shadow (_p2)
  logic [REG_AW-1:0] rd_p2;
  logic              regwrite_p2;

  logic [CNT_W-1:0]  stall_cnt;
  logic              stall;

  // A producing stage hits an ID-stage reader when it writes a nonzero rd
  // that matches rs, or rt when rt is actually read.
  function automatic logic raw_hit(
    input logic              wr,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rt,
    input logic              uses_rt
  );
    return wr && (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

  // Newest producer wins: EX/MEM before MEM/WB; register 0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] src,
    input logic              wr_mem,
    input logic [REG_AW-1:0] rd_mem,
    input logic              wr_wb,
    input logic [REG_AW-1:0] rd_wb
  );
    if (wr_mem && (rd_mem != '0) && (rd_mem == src)) return SEL_MEM;
    if (wr_wb && (rd_wb != '0) && (rd_wb == src))    return SEL_WB;
    return SEL_RF;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef HAZ_FORWARD_EN
  // Forwarding selects plus load-use detection against the load in ID/EX.
  always_comb begin
    fwd_a_sel_o = fwd_sel(rs_p0, regwrite_p1, rd_p1, regwrite_p2, rd_p2);
    fwd_b_sel_o = fwd_sel(rt_p0, regwrite_p1, rd_p1, regwrite_p2, rd_p2);
    stall       = raw_hit(memread_p0, rd_p0, id_rs_i, id_rt_i, id_uses_rt_i);
  end
`else
  // No forwarding: hold the reader until its producer has reached MEM/WB.
  always_comb begin
    fwd_a_sel_o = SEL_RF;
    fwd_b_sel_o = SEL_RF;
    stall       = raw_hit(regwrite_p0, rd_p0, id_rs_i, id_rt_i, id_uses_rt_i) ||
                  raw_hit(regwrite_p1, rd_p1, id_rs_i, id_rt_i, id_uses_rt_i);
  end

  // Shadow fields that only the forwarding path reads.
  logic unused_shadow;
  assign unused_shadow = ^{rs_p0, rt_p0, memread_p0, rd_p2, regwrite_p2};
`endif

  // Pipeline enables derived from the stall decision.
  always_comb begin
    stall_o       = stall;
    pc_write_o    = ~stall;
    ifid_write_o  = ~stall;
    idex_bubble_o = stall | flush_i;
    stall_cnt_o   = stall_cnt;
  end

  // ---- ID -> ID/EX (_p0): bubble zeroes every control field ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rs_p0       <= '0;
      rt_p0       <= '0;
      rd_p0       <= '0;
      regwrite_p0 <= 1'b0;
      memread_p0  <= 1'b0;
    end else if (idex_bubble_o) begin
      rs_p0       <= '0;
      rt_p0       <= '0;
      rd_p0       <= '0;
      regwrite_p0 <= 1'b0;
      memread_p0  <= 1'b0;
    end else begin
      rs_p0       <= id_rs_i;
      rt_p0       <= id_rt_i;
      rd_p0       <= id_rd_i;
      regwrite_p0 <= id_regwrite_i;
      memread_p0  <= id_memread_i;
    end
  end

  // ---- ID/EX -> EX/MEM (_p1) -> MEM/WB (_p2): always advance ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_p1       <= '0;
      regwrite_p1 <= 1'b0;
      rd_p2       <= '0;
      regwrite_p2 <= 1'b0;
    end else begin
      rd_p1       <= rd_p0;
      regwrite_p1 <= regwrite_p0;
      rd_p2       <= rd_p1;
      regwrite_p2 <= regwrite_p1;
    end
  end

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Bench for forward_hazard_ctrl: per-cycle vector table with hand-derived
// expectations for whichever build (HAZ_FORWARD_EN or not) is compiled, plus
// sequences for asynchronous reset mid-stall and counter saturation.
// The counter is narrowed to 3 bits so saturation is reachable quickly.
module tb_forward_hazard_ctrl;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 3;
`ifdef HAZ_FORWARD_EN
  localparam int STALLS_PER_RAW = 1;
`else
  localparam int STALLS_PER_RAW = 2;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              id_regwrite, id_memread, id_uses_rt, flush;
  logic [1:0]        fwd_a_sel, fwd_b_sel;
  logic              stall, pc_write, ifid_write, idex_bubble;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [REG_AW-1:0] rs, rt, rd;
    logic              rw, mr, ut, fl;
    logic [1:0]        fa, fb;
    logic              st;
    logic [CNT_W-1:0]  cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  forward_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_rd_i       (id_rd),
    .id_regwrite_i (id_regwrite),
    .id_memread_i  (id_memread),
    .id_uses_rt_i  (id_uses_rt),
    .flush_i       (flush),
    .fwd_a_sel_o   (fwd_a_sel),
    .fwd_b_sel_o   (fwd_b_sel),
    .stall_o       (stall),
    .pc_write_o    (pc_write),
    .ifid_write_o  (ifid_write),
    .idex_bubble_o (idex_bubble),
    .stall_cnt_o   (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time budget");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int rs, input int rt, input int rd, input int rw,
                       input int mr, input int ut, input int fl);
    id_rs       = rs[REG_AW-1:0];
    id_rt       = rt[REG_AW-1:0];
    id_rd       = rd[REG_AW-1:0];
    id_regwrite = rw[0];
    id_memread  = mr[0];
    id_uses_rt  = ut[0];
    flush       = fl[0];
  endtask

  task automatic add_vec(input int rs, input int rt, input int rd, input int rw,
                         input int mr, input int ut, input int fl,
                         input int fa, input int fb, input int st, input int cnt);
    vec_t v;
    v.rs = rs[REG_AW-1:0]; v.rt = rt[REG_AW-1:0]; v.rd = rd[REG_AW-1:0];
    v.rw = rw[0]; v.mr = mr[0]; v.ut = ut[0]; v.fl = fl[0];
    v.fa = fa[1:0]; v.fb = fb[1:0]; v.st = st[0]; v.cnt = cnt[CNT_W-1:0];
    vecs.push_back(v);
  endtask

  // Holds the current ID inputs while stalled; returns the stall cycles seen.
  task automatic hold_until_clear(output int n);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " fwd_a"}, int'(fwd_a_sel), 0);
    check({tag, " fwd_b"}, int'(fwd_b_sel), 0);
    check({tag, " stall"}, int'(stall), 0);
    check({tag, " pc_write"}, int'(pc_write), 1);
    check({tag, " ifid_write"}, int'(ifid_write), 1);
    check({tag, " bubble"}, int'(idex_bubble), 0);
    check({tag, " cnt"}, int'(stall_cnt), 0);
  endtask

  initial begin
    vec_t v, e;
    int   n;

    //       rs rt rd rw mr ut fl   fa fb st cnt
`ifdef HAZ_FORWARD_EN
    add_vec(1, 2, 3, 1, 0, 1, 0,  0, 0, 0, 0);  // add $3
    add_vec(3, 5, 4, 1, 0, 1, 0,  0, 0, 0, 0);  // sub $4,$3,$5
    add_vec(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);  // sub in EX: $3 from EX/MEM
    add_vec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);
    add_vec(1, 2, 3, 1, 0, 1, 0,  0, 0, 0, 0);  // add $3
    add_vec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0);  // nop
    add_vec(7, 3, 6, 1, 0, 1, 0,  0, 0, 0, 0);  // or $6,$7,$3
    add_vec(0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 0);  // or in EX: $3 from MEM/WB
    add_vec(1, 2, 3, 1, 0, 1, 0,  0, 0, 0, 0);  // add $3
    add_vec(4, 5, 3, 1, 0, 1, 0,  0, 0, 0, 0);  // add $3 again
    add_vec(3, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0);  // use $3
    add_vec(0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0);  // both write $3: EX/MEM wins
    add_vec(1, 8, 8, 1, 1, 0, 0,  0, 0, 0, 0);  // lw $8
    add_vec(8, 1, 9, 1, 0, 1, 0,  0, 0, 1, 0);  // add $9,$8,$1 -> stall
    add_vec(8, 1, 9, 1, 0, 1, 0,  0, 0, 0, 1);  // held, bubble in ID/EX
    add_vec(0, 0, 0, 0, 0, 0, 0,  2, 0, 0, 1);  // add in EX: $8 from MEM/WB
    add_vec(1, 2, 0, 1, 0, 1, 0,  0, 0, 0, 1);  // add $0
    add_vec(0, 0, 5, 1, 0, 1, 0,  0, 0, 0, 1);  // use $0
    add_vec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1);  // $0 never forwarded
    add_vec(1, 0, 0, 1, 1, 0, 0,  0, 0, 0, 1);  // lw $0
    add_vec(0, 0, 6, 1, 0, 1, 0,  0, 0, 0, 1);  // use $0: no load-use stall
    add_vec(2, 8, 8, 1, 1, 0, 0,  0, 0, 0, 1);  // lw $8
    add_vec(1, 8, 9, 1, 0, 1, 1,  0, 0, 1, 1);  // reads rt $8, flush too
    add_vec(1, 8, 9, 1, 0, 1, 0,  0, 0, 0, 2);  // held
    add_vec(0, 0, 0, 0, 0, 0, 0,  0, 2, 0, 2);  // rt from MEM/WB
    add_vec(0, 8, 8, 1, 1, 0, 0,  0, 0, 0, 2);  // lw $8
    add_vec(1, 8, 8, 1, 0, 0, 0,  0, 0, 0, 2);  // rt=$8 but not read: no stall
    add_vec(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 2);
    add_vec(3, 4, 7, 1, 0, 1, 1,  0, 0, 0, 2);  // flush without stall
    add_vec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2);
`else
    add_vec(1, 2, 3, 1, 0, 1, 0,  0, 0, 0, 0);  // add $3
    add_vec(3, 5, 4, 1, 0, 1, 0,  0, 0, 1, 0);  // sub uses $3: distance 1
    add_vec(3, 5, 4, 1, 0, 1, 0,  0, 0, 1, 1);
    add_vec(3, 5, 4, 1, 0, 1, 0,  0, 0, 0, 2);
    add_vec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2);
    add_vec(1, 2, 3, 1, 0, 1, 0,  0, 0, 0, 2);  // add $3
    add_vec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2);  // nop
    add_vec(7, 3, 6, 1, 0, 1, 0,  0, 0, 1, 2);  // or reads rt $3: distance 2
    add_vec(7, 3, 6, 1, 0, 1, 0,  0, 0, 0, 3);
    add_vec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3);
    add_vec(1, 2, 3, 1, 0, 1, 0,  0, 0, 0, 3);  // add $3
    add_vec(1, 3, 3, 1, 0, 0, 0,  0, 0, 0, 3);  // rt=$3 not read
    add_vec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3);
    add_vec(1, 2, 0, 1, 0, 1, 0,  0, 0, 0, 3);  // add $0
    add_vec(0, 0, 5, 1, 0, 1, 0,  0, 0, 0, 3);  // use $0: no stall
    add_vec(1, 8, 8, 1, 1, 0, 0,  0, 0, 0, 3);  // lw $8
    add_vec(8, 1, 9, 1, 0, 1, 0,  0, 0, 1, 3);  // load treated like ALU
    add_vec(8, 1, 9, 1, 0, 1, 0,  0, 0, 1, 4);
    add_vec(8, 1, 9, 1, 0, 1, 0,  0, 0, 0, 5);
    add_vec(2, 3, 9, 0, 0, 1, 0,  0, 0, 0, 5);  // no regwrite, rd=$9
    add_vec(9, 0, 1, 1, 0, 0, 0,  0, 0, 1, 5);  // $9 from add at EX/MEM
    add_vec(9, 0, 1, 1, 0, 0, 0,  0, 0, 0, 6);  // rw=0 at EX/MEM: no stall
    add_vec(0, 0, 3, 1, 0, 0, 1,  0, 0, 0, 6);  // add $3 flushed
    add_vec(3, 0, 2, 1, 0, 0, 0,  0, 0, 0, 6);  // flushed $3 causes nothing
    add_vec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 6);
    add_vec(1, 1, 4, 1, 0, 1, 0,  0, 0, 0, 6);  // add $4
    add_vec(4, 0, 5, 1, 0, 0, 1,  0, 0, 1, 6);  // stall with flush
    add_vec(4, 0, 5, 1, 0, 0, 0,  0, 0, 1, 7);  // counter saturates here
    add_vec(4, 0, 5, 1, 0, 0, 0,  0, 0, 0, 7);
    add_vec(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 7);
    add_vec(5, 0, 6, 1, 0, 0, 0,  0, 0, 1, 7);  // stall while saturated
    add_vec(5, 0, 6, 1, 0, 0, 0,  0, 0, 0, 7);
`endif

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      v = vecs[i];
      drive(int'(v.rs), int'(v.rt), int'(v.rd), int'(v.rw), int'(v.mr),
            int'(v.ut), int'(v.fl));
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      check($sformatf("v%0d fwd_a", i), int'(fwd_a_sel), int'(e.fa));
      check($sformatf("v%0d fwd_b", i), int'(fwd_b_sel), int'(e.fb));
      check($sformatf("v%0d stall", i), int'(stall), int'(e.st));
      check($sformatf("v%0d pc_write", i), int'(pc_write), int'(!e.st));
      check($sformatf("v%0d ifid_write", i), int'(ifid_write), int'(!e.st));
      check($sformatf("v%0d bubble", i), int'(idex_bubble), int'(e.st | e.fl));
      check($sformatf("v%0d cnt", i), int'(stall_cnt), int'(e.cnt));
    end

    // Reset asserted in the middle of a load-use stall.
    repeat (3) begin
      @(posedge clk);
      #1 drive(0, 0, 0, 0, 0, 0, 0);
    end
    @(posedge clk);
    #1 drive(1, 8, 8, 1, 1, 0, 0);
    @(posedge clk);
    #1 drive(8, 1, 9, 1, 0, 1, 0);
    @(negedge clk);
    check("pre-reset stall", int'(stall), 1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    @(posedge clk);
    #2;
    check_reset_outputs("held reset");
    drive(1, 8, 8, 1, 1, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 drive(8, 1, 9, 1, 0, 1, 0);
    hold_until_clear(n);
    check("post-reset stall cycles", n, STALLS_PER_RAW);
    check("post-reset cnt", int'(stall_cnt), STALLS_PER_RAW);

    // Repeated RAW pairs push the 3-bit counter into saturation.
    for (int it = 0; it < 10; it++) begin
      @(posedge clk);
      #1 drive(1, 8, 8, 1, 1, 0, 0);
      @(posedge clk);
      #1 drive(8, 1, 9, 1, 0, 1, 0);
      hold_until_clear(n);
      check($sformatf("raw%0d stall cycles", it), n, STALLS_PER_RAW);
      @(posedge clk);
      #1 drive(0, 0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    check("saturated cnt", int'(stall_cnt), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/forward_hazard_ctrl.md
# forward_hazard_ctrl

- Generates the 2-bit select codes for the pipeline's two 3-input EX-stage operand muxes, plus the load-use stall controls.
- Keeps its own shadow copy of the ID/EX, EX/MEM and MEM/WB control fields (rs, rt, rd, RegWrite, MemRead), so the hazard and forwarding decisions are self-contained.
- Sits beside the decoder: consumes decoded ID-stage fields; drives the operand-mux selects, PC write enable, IF/ID write enable and the ID/EX bubble.

## Interface
- REG_AW, 5, register-address width
- CNT_W, 16, width of stall counter
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- id_rs_i  in  REG_AW  rs of instruction in ID
- id_rt_i  in  REG_AW  rt of instruction in ID
- id_rd_i  in  REG_AW  final destination register (after RegDst selection)
- id_regwrite_i  in  1  ID instruction writes register file
- id_memread_i  in  1  ID instruction is a load
- id_uses_rt_i  in  1  ID instruction reads rt as a source
- flush_i  in  1  squash instruction entering EX (branch taken)
- fwd_a_sel_o  out  2  operand-A mux select
- fwd_b_sel_o  out  2  operand-B mux select
- stall_o  out  1  hazard stall this cycle
- pc_write_o  out  1  PC write enable (= ~stall_o)
- ifid_write_o  out  1  IF/ID write enable (= ~stall_o)
- idex_bubble_o  out  1  zero ID/EX control fields (= stall_o | flush_i)
- stall_cnt_o  out  CNT_W  saturating count of stall cycles

## Operation
- Select encoding, shared with the operand muxes:
  - 0 = register-file value.
  - 1 = EX/MEM ALU result.
  - 2 = MEM/WB write-back data.
  - Code 3 is never driven.
- Shadow stages, updated each rising edge:
  - ID/EX ← ID inputs, or a bubble (regwrite=0, memread=0, rs=rt=rd=0) when idex_bubble_o=1.
  - EX/MEM ← ID/EX.
  - MEM/WB ← EX/MEM.
  - EX/MEM and MEM/WB always advance; stall never freezes them.
- Forwarding (combinational from shadow state), operand A uses ID/EX.rs:
  - If EX/MEM.regwrite && EX/MEM.rd≠0 && EX/MEM.rd==ID/EX.rs → 1.
  - Else if MEM/WB.regwrite && MEM/WB.rd≠0 && MEM/WB.rd==ID/EX.rs → 2.
  - Else → 0.
- Operand B: same rule using ID/EX.rt.
- EX/MEM has priority over MEM/WB (newest value wins).
- Register 0 is never forwarded.
- Load-use stall:
  - stall_o=1 when ID/EX.memread && ID/EX.rd≠0 && (ID/EX.rd==id_rs_i || (id_uses_rt_i && ID/EX.rd==id_rt_i)).
  - The stall lasts exactly one cycle, because the bubble clears the ID/EX.memread condition.
- flush_i with stall_o: the bubble is inserted once; pc_write_o/ifid_write_o still follow stall_o.
- stall_cnt_o increments on each clock with stall_o=1 and saturates at all-ones.

## Timing
- Selects and stall outputs are combinational from the shadow registers and current ID inputs; they are valid in the same cycle.
- Load → dependent instruction:
  - 1 stall cycle.
  - The dependent instruction's EX cycle then sees the load in MEM/WB → select 2.
- ALU → dependent instruction, back-to-back: select 1, no stall.
- ALU → dependent instruction, one instruction apart: select 2, no stall.
- Register-file write-before-read is assumed; no hazard at distance 3.
- Reset values (asynchronous, rst_i=0):
  - All shadow fields 0.
  - fwd_a_sel_o=fwd_b_sel_o=0.
  - stall_o=0, pc_write_o=1, ifid_write_o=1, idex_bubble_o=0 (with flush_i=0).
  - stall_cnt_o=0.
- Reset asserted mid-stall clears all state immediately; the first edge after release loads ID/EX normally.

## Configuration
- HAZ_FORWARD_EN defined: forwarding and load-use stall exactly as above.
- HAZ_FORWARD_EN undefined:
  - fwd_a_sel_o and fwd_b_sel_o are tied to 0.
  - stall_o=1 whenever ID/EX or EX/MEM has regwrite=1 with rd≠0 matching id_rs_i, or id_rt_i when id_uses_rt_i.
  - RAW distance 1 → 2 stall cycles; distance 2 → 1 stall cycle.
  - Loads are not treated specially.
  - stall_cnt_o counts these stalls the same way.

## Test plan
- Reset: hold rst_i=0 mid-stream → all outputs at their reset values asynchronously; stall_cnt_o=0.
- add $3←$1,$2 then sub $4←$3,$5 (forwarding enabled) → next cycle fwd_a_sel_o=1, stall_o=0.
- add $3, then nop, then or $6←$7,$3 (id_uses_rt=1) → fwd_b_sel_o=2 during or's EX.
- Both stages write $3 (add $3; add $3; use $3) → fwd_a_sel_o=1 (EX/MEM priority).
- lw $8 then add $9←$8,$1 → stall_o=1 for exactly 1 cycle, pc_write_o=0, idex_bubble_o=1; then fwd_a_sel_o=2; stall_cnt_o=1.
- Writes to $0 (add $0; use $0) → selects stay 0, no stall.
- HAZ_FORWARD_EN undefined, add $3 then sub using $3 → stall_o=1 for 2 cycles, selects 0, stall_cnt_o=2.
